inst_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface for the 3BC processor.
- Owns the program counter (PC) and drives the 10-bit InstAddress into the combinational instruction ROM.
- Captures the returned 9-bit InstOut into an instruction register (IR) and presents it to decode with a valid flag.
- Handles start, halt, stall and absolute/relative branch redirection, and keeps a retired-instruction counter for the testbench.

---
 rtl/inst_fetch_unit.sv | 101 ++++++++++
 tb/tb_inst_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit for the 3BC processor: owns the PC, drives the
// instruction ROM address, registers the returned word and counts retirements.
module inst_fetch_unit #(
  parameter int ADDR_W = 10,
  parameter int INST_W = 9,
  parameter int OFF_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  output logic [ADDR_W-1:0] InstAddress,
  input  logic [INST_W-1:0] InstOut,
  output logic [INST_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstPC,
  output logic              InstValid,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic              BranchRel,
  input  logic [OFF_W-1:0]  BranchOffset,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Halt,
  output logic              Done,
  output logic [CNT_W-1:0]  InstCount
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] branch_dest;
  logic [CNT_W-1:0]  count_inc;

  // Relative offsets are sign-extended to the address width; the add wraps.
  always_comb begin
    branch_dest = BranchTarget;
    if (BranchRel)
      branch_dest = InstPC + {{(ADDR_W-OFF_W){BranchOffset[OFF_W-1]}}, BranchOffset};
  end

  // Retirement counter sticks at all-ones instead of wrapping.
  always_comb begin
    count_inc = InstCount;
    if (InstCount != '1)
      count_inc = InstCount + CNT_W'(1);
  end

  assign InstAddress = pc;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      pc        <= '0;
      Instr     <= '0;
      InstPC    <= '0;
      InstValid <= 1'b0;
      Done      <= 1'b0;
      InstCount <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            pc        <= StartAddr;
            InstValid <= 1'b0;
            Done      <= 1'b0;
            InstCount <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (Stall) begin
            // Everything holds; Halt/BranchTaken must be re-presented later.
          end else if (InstValid && Halt) begin
            state     <= HALTED;
            Done      <= 1'b1;
            InstValid <= 1'b0;
            InstCount <= count_inc;
          end else if (InstValid && BranchTaken) begin
            pc        <= branch_dest;
            InstValid <= 1'b0;
            InstCount <= count_inc;
          end else begin
            Instr     <= InstOut;
            InstPC    <= pc;
            InstValid <= 1'b1;
            pc        <= pc + ADDR_W'(1);
            if (InstValid)
              InstCount <= count_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_inst_fetch_unit;
  localparam int ADDR_W = 10;
  localparam int INST_W = 9;
  localparam int OFF_W  = 8;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset, Start, Stall, BranchTaken, BranchRel, Halt;
  logic [ADDR_W-1:0] StartAddr, BranchTarget, InstAddress, InstPC;
  logic [OFF_W-1:0]  BranchOffset;
  logic [INST_W-1:0] InstOut, Instr;
  logic              InstValid, Done;
  logic [CNT_W-1:0]  InstCount;

  logic [INST_W-1:0] rom [DEPTH];

  always #5 Clk = ~Clk;
  assign InstOut = rom[InstAddress];

  inst_fetch_unit #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W),
    .OFF_W (OFF_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .InstAddress (InstAddress),
    .InstOut     (InstOut),
    .Instr       (Instr),
    .InstPC      (InstPC),
    .InstValid   (InstValid),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchRel   (BranchRel),
    .BranchOffset(BranchOffset),
    .BranchTarget(BranchTarget),
    .Halt        (Halt),
    .Done        (Done),
    .InstCount   (InstCount)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers, "running" flag instead of a state code.
  int m_pc, m_ir, m_ipc, m_cnt;
  bit m_val, m_done, m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int off;
    if (!Reset) begin
      m_pc = 0; m_ir = 0; m_ipc = 0; m_cnt = 0;
      m_val = 0; m_done = 0; m_run = 0;
    end else if (!m_run) begin
      if (Start) begin
        m_pc = int'(StartAddr); m_val = 0; m_done = 0; m_cnt = 0; m_run = 1;
      end
    end else if (Stall) begin
    end else if (m_val && Halt) begin
      m_run = 0; m_done = 1; m_val = 0;
      if (m_cnt < CMAX) m_cnt++;
    end else if (m_val && BranchTaken) begin
      if (BranchRel) begin
        off = int'(BranchOffset);
        if (off >= (1 << (OFF_W - 1))) off -= (1 << OFF_W);
        m_pc = ((m_ipc + off) % DEPTH + DEPTH) % DEPTH;
      end else begin
        m_pc = int'(BranchTarget);
      end
      m_val = 0;
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      if (m_val && m_cnt < CMAX) m_cnt++;
      m_ir = int'(rom[m_pc]); m_ipc = m_pc; m_val = 1;
      m_pc = (m_pc + 1) % DEPTH;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check("InstAddress", 32'(InstAddress), 32'(m_pc));
    check("Instr",       32'(Instr),       32'(m_ir));
    check("InstPC",      32'(InstPC),      32'(m_ipc));
    check("InstValid",   32'(InstValid),   32'(m_val));
    check("Done",        32'(Done),        32'(m_done));
    check("InstCount",   32'(InstCount),   32'(m_cnt));
  endtask

  task automatic idle_inputs();
    Start = 0; StartAddr = '0; Stall = 0; BranchTaken = 0; BranchRel = 0;
    BranchOffset = '0; BranchTarget = '0; Halt = 0;
  endtask

  typedef struct {
    bit              start;
    bit              bt;
    bit              brel;
    logic [OFF_W-1:0]  off;
    logic [ADDR_W-1:0] tgt;
    bit              exp_valid;
    int              exp_ipc;
    int              exp_instr;
    int              exp_cnt;
  } vec_t;

  vec_t tbl [12];
  int   cnt_before;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = INST_W'((i + 1) % 512);
    idle_inputs();
    Reset = 0;
    step(); step();
    Reset = 1;
    step(); step();
    check("idle_no_valid", 32'(InstValid), 32'd0);

    // Start at 0, straight-line, relative branch -3 from 5, absolute to 1020,
    // then a BranchTaken during the bubble that must be ignored.
    tbl[0]  = '{1, 0, 0, 8'h00, 10'd0,    0, 0,    0,   0};
    tbl[1]  = '{0, 0, 0, 8'h00, 10'd0,    1, 0,    1,   0};
    tbl[2]  = '{0, 0, 0, 8'h00, 10'd0,    1, 1,    2,   1};
    tbl[3]  = '{0, 0, 0, 8'h00, 10'd0,    1, 2,    3,   2};
    tbl[4]  = '{0, 0, 0, 8'h00, 10'd0,    1, 3,    4,   3};
    tbl[5]  = '{0, 0, 0, 8'h00, 10'd0,    1, 4,    5,   4};
    tbl[6]  = '{0, 0, 0, 8'h00, 10'd0,    1, 5,    6,   5};
    tbl[7]  = '{0, 1, 1, 8'hFD, 10'd0,    0, 5,    6,   6};
    tbl[8]  = '{0, 0, 0, 8'h00, 10'd0,    1, 2,    3,   6};
    tbl[9]  = '{0, 1, 0, 8'h00, 10'd1020, 0, 2,    3,   7};
    tbl[10] = '{0, 1, 0, 8'h00, 10'd5,    1, 1020, 509, 7};
    tbl[11] = '{0, 0, 0, 8'h00, 10'd0,    1, 1021, 510, 8};
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      Start = tbl[i].start; BranchTaken = tbl[i].bt; BranchRel = tbl[i].brel;
      BranchOffset = tbl[i].off; BranchTarget = tbl[i].tgt;
      step();
      check("tbl_valid", 32'(InstValid), 32'(tbl[i].exp_valid));
      check("tbl_pc",    32'(InstPC),    32'(tbl[i].exp_ipc));
      check("tbl_instr", 32'(Instr),     32'(tbl[i].exp_instr));
      check("tbl_count", 32'(InstCount), 32'(tbl[i].exp_cnt));
    end

    // Halt, restart at 1022 and wrap through 0.
    idle_inputs(); Halt = 1; step();
    check("halt_done", 32'(Done), 32'd1);
    idle_inputs(); Start = 1; StartAddr = 10'd1022; step();
    check("restart_done_clr", 32'(Done), 32'd0);
    idle_inputs();
    step(); check("wrap_pc0", 32'(InstPC), 32'd1022);
    step(); check("wrap_pc1", 32'(InstPC), 32'd1023);
    step(); check("wrap_pc2", 32'(InstPC), 32'd0);
    step(); check("wrap_pc3", 32'(InstPC), 32'd1);
    for (int i = 0; i < 6; i++) step();
    check("at_rom7", 32'(Instr), 32'd8);

    // Stall for 3 cycles with Halt asserted, then Halt after release.
    cnt_before = int'(InstCount);
    check("pre_stall_count", 32'(cnt_before), 32'd9);
    Stall = 1; Halt = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr",  32'(InstAddress), 32'd8);
      check("stall_instr", 32'(Instr),       32'd8);
      check("stall_count", 32'(InstCount),   32'd9);
      check("stall_done",  32'(Done),        32'd0);
    end
    Stall = 0; step();
    check("halt2_done",  32'(Done),      32'd1);
    check("halt2_valid", 32'(InstValid), 32'd0);
    check("halt2_count", 32'(InstCount), 32'd10);

    // Restart from HALTED at 16; Start during RUN has no effect.
    idle_inputs(); Start = 1; StartAddr = 10'd16; step();
    check("rs_count", 32'(InstCount), 32'd0);
    check("rs_done",  32'(Done),      32'd0);
    idle_inputs(); step();
    check("rs_instr", 32'(Instr),  32'd17);
    check("rs_pc",    32'(InstPC), 32'd16);
    Start = 1; StartAddr = 10'd100; step();
    check("run_start_ignored", 32'(InstPC), 32'd17);
    idle_inputs();

    // Reset mid-run abandons the program.
    Reset = 0; step(); step();
    check("rst_valid", 32'(InstValid), 32'd0);
    check("rst_count", 32'(InstCount), 32'd0);
    check("rst_addr",  32'(InstAddress), 32'd0);
    Reset = 1; step();

    // Randomized run against the model.
    for (int i = 0; i < DEPTH; i++) rom[i] = INST_W'($urandom);
    for (int n = 0; n < 4000; n++) begin
      Reset        = ($urandom_range(0, 199) != 0);
      Start        = ($urandom_range(0, 15) == 0);
      StartAddr    = ADDR_W'($urandom);
      Stall        = ($urandom_range(0, 3) == 0);
      BranchTaken  = ($urandom_range(0, 5) == 0);
      BranchRel    = $urandom_range(0, 1) == 1;
      BranchOffset = OFF_W'($urandom);
      BranchTarget = ADDR_W'($urandom);
      Halt         = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
